instr_fetch: RTL and testbench

- Instruction fetch unit that produces the 32-bit `ir` consumed by the sisc datapath/control top level.
- Owns the program counter.
- Reads instruction memory over a req/ack handshake and accepts PC redirects (branches) from the control unit.
- Sits between instruction memory and the sisc core, replacing the testbench-driven `ir`.

---
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
//==============================================================================
// instr_fetch : instruction fetch unit. It owns the PC, reads instruction
//               memory over a req/ack handshake and accepts branch redirects.
// Rev 1.0
//==============================================================================
`default_nettype none

module instr_fetch #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        state_q,     state_d;
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [DATA_W-1:0] ir_q,        ir_d;
  logic              ir_valid_q,  ir_valid_d;
  logic              mem_req_q,   mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_valid_q, pend_valid_d;

  logic [ADDR_W-1:0] fetch_addr_w;
  logic [ADDR_W-1:0] seq_addr_w;

  // A redirect coincident with a fetch is applied before the fetch issues.
  assign fetch_addr_w = pc_load ? br_addr : pc_q;
  assign seq_addr_w   = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;

    case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_addr_w;
          pc_d       = fetch_addr_w;
          ir_valid_d = 1'b0;
          state_d    = S_WAIT;
        end else if (pc_load) begin
          pc_d = br_addr;
        end
      end
      S_WAIT: begin
        if (mem_ack && mem_req_q) begin
          ir_d         = mem_rdata;
          ir_valid_d   = 1'b1;
          mem_req_d    = 1'b0;
          pend_valid_d = 1'b0;
          state_d      = S_IDLE;
          // Same-edge redirect beats a buffered one, which beats sequential.
          if (pc_load)           pc_d = br_addr;
          else if (pend_valid_q) pc_d = pend_addr_q;
          else                   pc_d = seq_addr_w;
        end else if (pc_load) begin
          pend_addr_d  = br_addr;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc       = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//==============================================================================
// tb_instr_fetch : directed self-checking bench for instr_fetch.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        fetch_req;
  logic        pc_load;
  logic [15:0] br_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic [15:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .RESET_PC (16'h0000)
  ) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .fetch_req (fetch_req),
    .pc_load   (pc_load),
    .br_addr   (br_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_f = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; br_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset then idle
    tick(); tick();
    chk("rst_pc",       32'(pc),       32'h0);
    chk("rst_ir",       ir,            32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_mem_req",  32'(mem_req),  32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    rst_f = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_ir",       ir,            32'h0);
    chk("idle_ack_ir_valid", 32'(ir_valid), 32'h0);
    chk("idle_ack_pc",       32'(pc),       32'h0);

    // Zero-wait fetch
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("zw_mem_req",  32'(mem_req),  32'h1);
    chk("zw_mem_addr", 32'(mem_addr), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1A2B3C4D;
    tick();
    mem_ack = 1'b0;
    chk("zw_ir",       ir,            32'h1A2B3C4D);
    chk("zw_ir_valid", 32'(ir_valid), 32'h1);
    chk("zw_pc",       32'(pc),       32'h1);
    chk("zw_req_drop", 32'(mem_req),  32'h0);

    // Wait states plus redirect in the 2nd wait cycle
    pc_load = 1'b1; br_addr = 16'h0005;
    tick();
    pc_load = 1'b0;
    chk("ws_pc_load",    32'(pc),       32'h5);
    chk("ws_valid_kept", 32'(ir_valid), 32'h1);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("ws_mem_addr0", 32'(mem_addr), 32'h5);
    chk("ws_valid_drop", 32'(ir_valid), 32'h0);
    chk("ws_ir_held",   ir,            32'h1A2B3C4D);
    fetch_req = 1'b1;               // ignored in WAIT
    tick();
    fetch_req = 1'b0;
    chk("ws_mem_addr1", 32'(mem_addr), 32'h5);
    pc_load = 1'b1; br_addr = 16'h0040;
    tick();
    pc_load = 1'b0;
    chk("ws_mem_addr2", 32'(mem_addr), 32'h5);
    chk("ws_mem_req2",  32'(mem_req),  32'h1);
    tick();
    chk("ws_mem_addr3", 32'(mem_addr), 32'h5);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEBABE;
    tick();
    mem_ack = 1'b0;
    chk("ws_ir",       ir,            32'hCAFEBABE);
    chk("ws_ir_valid", 32'(ir_valid), 32'h1);
    chk("ws_pc_redir", 32'(pc),       32'h40);
    chk("ws_no_queue", 32'(mem_req),  32'h0);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("ws_next_addr", 32'(mem_addr), 32'h40);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 1'b0;
    chk("ws_next_pc", 32'(pc), 32'h41);

    // Redirect on the ack edge beats a buffered redirect
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("ae_mem_addr", 32'(mem_addr), 32'h41);
    pc_load = 1'b1; br_addr = 16'h0200;
    tick();
    br_addr = 16'h0300; mem_ack = 1'b1; mem_rdata = 32'h22222222;
    tick();
    pc_load = 1'b0; mem_ack = 1'b0;
    chk("ae_pc", 32'(pc), 32'h300);
    chk("ae_ir", ir,      32'h22222222);

    // Simultaneous load and fetch in IDLE
    pc_load = 1'b1; br_addr = 16'h0003;
    tick();
    chk("sl_pc3", 32'(pc), 32'h3);
    fetch_req = 1'b1; br_addr = 16'h0100;
    tick();
    fetch_req = 1'b0; pc_load = 1'b0;
    chk("sl_mem_addr", 32'(mem_addr), 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h33333333;
    tick();
    mem_ack = 1'b0;
    chk("sl_pc", 32'(pc), 32'h101);

    // Wrap-around
    pc_load = 1'b1; br_addr = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("wr_mem_addr", 32'(mem_addr), 32'hFFFF);
    mem_ack = 1'b1; mem_rdata = 32'h44444444;
    tick();
    mem_ack = 1'b0;
    chk("wr_pc",       32'(pc),       32'h0);
    chk("wr_ir_valid", 32'(ir_valid), 32'h1);

    // Reset mid-fetch, late ack ignored
    pc_load = 1'b1; br_addr = 16'h0007;
    tick();
    pc_load = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("rm_mem_addr", 32'(mem_addr), 32'h7);
    tick();
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0;
    chk("rm_mem_req",  32'(mem_req),  32'h0);
    chk("rm_pc",       32'(pc),       32'h0);
    chk("rm_ir_valid", 32'(ir_valid), 32'h0);
    chk("rm_mem_addr0", 32'(mem_addr), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("rm_late_ir",    ir,            32'h0);
    chk("rm_late_valid", 32'(ir_valid), 32'h0);
    chk("rm_late_pc",    32'(pc),       32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
